div_unit: RTL

Iterative 32-bit divider for the EX stage, executing MIPS DIV/DIVU alongside the combinational ALU. One radix-2 restoring iteration per cycle; quotient goes to LO and remainder to HI. A start/valid handshake lets the pipeline stall while the unit is busy, and a cancel input lets the pipeline flush it on an exception.

---
 rtl/div_unit.sv | 123 ++++++++++++
 1 files changed

// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for MIPS DIV/DIVU: quotient to LO, remainder to HI.
// One iteration per cycle, start/valid handshake, cancel for pipeline flush.
module div_unit #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             start,
   input  logic             is_signed,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cancel,
   output logic             busy,
   output logic             valid,
   output logic [WIDTH-1:0] lo,
   output logic [WIDTH-1:0] hi
);

   localparam int unsigned CNT_W = $clog2(WIDTH);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DIV  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t             state_q;
   logic [WIDTH-1:0]   dvd_q, dvs_q, rem_q, lo_q, hi_q;
   logic [CNT_W-1:0]   cnt_q;
   logic               asign_q, bsign_q, signed_q;
   logic               busy_q, valid_q;

   logic [WIDTH-1:0]   abs_a, abs_b, part_lo, diff, rem_d, dvd_d, lo_fix, hi_fix;
   logic               ge, neg_quo, neg_rem;

   // One restoring step; the compare keeps rem[MSB] so divisors >= 2^31 stay exact.
   always_comb begin
      abs_a   = (is_signed && a[WIDTH-1]) ? (~a + WIDTH'(1)) : a;
      abs_b   = (is_signed && b[WIDTH-1]) ? (~b + WIDTH'(1)) : b;
      part_lo = {rem_q[WIDTH-2:0], dvd_q[WIDTH-1]};
      ge      = {rem_q, dvd_q[WIDTH-1]} >= {1'b0, dvs_q};
      diff    = part_lo - dvs_q;
      rem_d   = ge ? diff : part_lo;
      dvd_d   = {dvd_q[WIDTH-2:0], ge};
      neg_quo = signed_q & (asign_q ^ bsign_q);
      neg_rem = signed_q & asign_q;
      lo_fix  = neg_quo ? (~dvd_d + WIDTH'(1)) : dvd_d;
      hi_fix  = neg_rem ? (~rem_d + WIDTH'(1)) : rem_d;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q  <= IDLE;
         dvd_q    <= '0;
         dvs_q    <= '0;
         rem_q    <= '0;
         cnt_q    <= '0;
         asign_q  <= 1'b0;
         bsign_q  <= 1'b0;
         signed_q <= 1'b0;
         lo_q     <= '0;
         hi_q     <= '0;
         busy_q   <= 1'b0;
         valid_q  <= 1'b0;
      end else begin
         valid_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (cancel) begin
                  state_q <= IDLE;
               end else if (start) begin
                  if (b == '0) begin
                     lo_q    <= '1;
                     hi_q    <= a;
                     valid_q <= 1'b1;
                     state_q <= DONE;
                  end else begin
                     dvd_q    <= abs_a;
                     dvs_q    <= abs_b;
                     rem_q    <= '0;
                     cnt_q    <= '0;
                     asign_q  <= is_signed & a[WIDTH-1];
                     bsign_q  <= is_signed & b[WIDTH-1];
                     signed_q <= is_signed;
                     busy_q   <= 1'b1;
                     state_q  <= DIV;
                  end
               end
            end
            DIV: begin
               if (cancel) begin
                  busy_q  <= 1'b0;
                  state_q <= IDLE;
               end else begin
                  rem_q <= rem_d;
                  dvd_q <= dvd_d;
                  cnt_q <= cnt_q + CNT_W'(1);
                  if (cnt_q == CNT_W'(WIDTH - 1)) begin
                     lo_q    <= lo_fix;
                     hi_q    <= hi_fix;
                     busy_q  <= 1'b0;
                     valid_q <= 1'b1;
                     state_q <= DONE;
                  end
               end
            end
            DONE: begin
               state_q <= IDLE;
            end
            default: begin
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign busy  = busy_q;
   assign valid = valid_q;
   assign lo    = lo_q;
   assign hi    = hi_q;

endmodule
